// File: rtl/axi4_bram_ctrl.sv
// AXI4 slave fronting an internal single-port word memory.
// Independent write and read engines share the one port through an alternating arbiter.
module axi4_bram_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                resetn,
  output logic                bram_axi4_aw_ready,
  input  logic                bram_axi4_aw_valid,
  input  logic [ID_W-1:0]     bram_axi4_aw_id,
  input  logic [30:0]         bram_axi4_aw_addr,
  input  logic [7:0]          bram_axi4_aw_len,
  input  logic [2:0]          bram_axi4_aw_size,
  input  logic [1:0]          bram_axi4_aw_burst,
  output logic                bram_axi4_w_ready,
  input  logic                bram_axi4_w_valid,
  input  logic [DATA_W-1:0]   bram_axi4_w_data,
  input  logic [DATA_W/8-1:0] bram_axi4_w_strb,
  input  logic                bram_axi4_w_last,
  input  logic                bram_axi4_b_ready,
  output logic                bram_axi4_b_valid,
  output logic [ID_W-1:0]     bram_axi4_b_id,
  output logic [1:0]          bram_axi4_b_resp,
  output logic                bram_axi4_ar_ready,
  input  logic                bram_axi4_ar_valid,
  input  logic [ID_W-1:0]     bram_axi4_ar_id,
  input  logic [30:0]         bram_axi4_ar_addr,
  input  logic [7:0]          bram_axi4_ar_len,
  input  logic [2:0]          bram_axi4_ar_size,
  input  logic [1:0]          bram_axi4_ar_burst,
  input  logic                bram_axi4_r_ready,
  output logic                bram_axi4_r_valid,
  output logic [ID_W-1:0]     bram_axi4_r_id,
  output logic [DATA_W-1:0]   bram_axi4_r_data,
  output logic [1:0]          bram_axi4_r_resp,
  output logic                bram_axi4_r_last
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - LB;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_t;

  function automatic logic [30:0] next_addr(input logic [30:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [30:0] step;
    logic [30:0] mask;
    step = 31'd1 << size;
    mask = (({23'd0, len} + 31'd1) << size) - 31'd1;
    case (burst)
      2'b01:   return a + step;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a;
    endcase
  endfunction

  function automatic logic bad_cfg(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst);
    return (32'(size) > LB) || (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                  (len == 8'd7) || (len == 8'd15)));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  w_state_t        w_state;
  logic [ID_W-1:0] w_id;
  logic [30:0]     w_addr;
  logic [7:0]      w_len, w_beat;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic            w_bad, w_err;

  r_state_t        r_state;
  logic [30:0]     r_addr;
  logic [7:0]      r_len, r_beat;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_bad;

  logic            last_wr;
  logic            wr_req, rd_req, wgrant, rgrant, w_last_bad;
  logic [IDX_W-1:0] widx, ridx;

  // Conflicts go to the engine that did not hold the port most recently.
  always_comb begin
    wr_req     = resetn && (w_state == W_DATA) && bram_axi4_w_valid;
    rd_req     = resetn && (r_state == R_ISSUE);
    wgrant     = wr_req && (!rd_req || !last_wr);
    rgrant     = rd_req && (!wr_req || last_wr);
    widx       = w_addr[ADDR_W-1:LB];
    ridx       = r_addr[ADDR_W-1:LB];
    w_last_bad = bram_axi4_w_last != (w_beat == w_len);
  end

  assign bram_axi4_w_ready = wgrant;
  assign bram_axi4_b_id    = w_id;
  assign bram_axi4_r_data  = bram_axi4_r_resp[1] ? '0 : rd_q;

  always_ff @(posedge clock) begin
    if (wgrant && !w_bad) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bram_axi4_w_strb[i]) mem[widx][i*8 +: 8] <= bram_axi4_w_data[i*8 +: 8];
      end
    end
    if (rgrant) rd_q <= mem[ridx];
  end

  always_ff @(posedge clock) begin
    if (!resetn)     last_wr <= 1'b1;
    else if (wgrant) last_wr <= 1'b1;
    else if (rgrant) last_wr <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_state            <= W_IDLE;
      bram_axi4_aw_ready <= 1'b0;
      bram_axi4_b_valid  <= 1'b0;
      bram_axi4_b_resp   <= 2'b00;
      w_bad              <= 1'b0;
      w_err              <= 1'b0;
      w_beat             <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bram_axi4_aw_ready && bram_axi4_aw_valid) begin
            w_id               <= bram_axi4_aw_id;
            w_addr             <= bram_axi4_aw_addr;
            w_len              <= bram_axi4_aw_len;
            w_size             <= bram_axi4_aw_size;
            w_burst            <= bram_axi4_aw_burst;
            w_bad              <= bad_cfg(bram_axi4_aw_size, bram_axi4_aw_len, bram_axi4_aw_burst);
            w_err              <= 1'b0;
            w_beat             <= '0;
            bram_axi4_aw_ready <= 1'b0;
            w_state            <= W_DATA;
          end else begin
            bram_axi4_aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wgrant) begin
            if (w_last_bad) w_err <= 1'b1;
            if (w_beat == w_len) begin
              w_state           <= W_RESP;
              bram_axi4_b_valid <= 1'b1;
              bram_axi4_b_resp  <= (w_bad || w_err || w_last_bad) ? 2'b10 : 2'b00;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            end
          end
        end
        W_RESP: begin
          if (bram_axi4_b_ready) begin
            bram_axi4_b_valid  <= 1'b0;
            bram_axi4_b_resp   <= 2'b00;
            bram_axi4_aw_ready <= 1'b1;
            w_state            <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state            <= R_IDLE;
      bram_axi4_ar_ready <= 1'b0;
      bram_axi4_r_valid  <= 1'b0;
      bram_axi4_r_resp   <= 2'b00;
      bram_axi4_r_last   <= 1'b0;
      r_bad              <= 1'b0;
      r_beat             <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bram_axi4_ar_ready && bram_axi4_ar_valid) begin
            bram_axi4_r_id     <= bram_axi4_ar_id;
            r_addr             <= bram_axi4_ar_addr;
            r_len              <= bram_axi4_ar_len;
            r_size             <= bram_axi4_ar_size;
            r_burst            <= bram_axi4_ar_burst;
            r_bad              <= bad_cfg(bram_axi4_ar_size, bram_axi4_ar_len, bram_axi4_ar_burst);
            r_beat             <= '0;
            bram_axi4_ar_ready <= 1'b0;
            r_state            <= R_ISSUE;
          end else begin
            bram_axi4_ar_ready <= 1'b1;
          end
        end
        R_ISSUE: begin
          if (rgrant) begin
            bram_axi4_r_valid <= 1'b1;
            bram_axi4_r_last  <= (r_beat == r_len);
            bram_axi4_r_resp  <= r_bad ? 2'b10 : 2'b00;
            r_state           <= R_DATA;
          end
        end
        R_DATA: begin
          if (bram_axi4_r_ready) begin
            bram_axi4_r_valid <= 1'b0;
            bram_axi4_r_last  <= 1'b0;
            if (r_beat == r_len) begin
              bram_axi4_r_resp   <= 2'b00;
              bram_axi4_ar_ready <= 1'b1;
              r_state            <= R_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= next_addr(r_addr, r_size, r_len, r_burst);
              r_state <= R_ISSUE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
